// File: rtl/move_cmd_scheduler_pkg.sv
// Shared types for the move command scheduler: direction codes and issue FSM states.
package move_cmd_scheduler_pkg;

  typedef enum logic [1:0] {
    DIR_NONE     = 2'd0,
    DIR_STRAIGHT = 2'd1,
    DIR_LEFT     = 2'd2,
    DIR_RIGHT    = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } issue_st_e;

  // Counter width that always holds 0..n-1, with at least one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/move_cmd_scheduler_if.sv
// Move handshake towards the game core: direction plus valid/ready.
interface move_cmd_scheduler_if;
  logic [1:0] mv_dir;
  logic       mv_valid;
  logic       mv_ready;

  modport master (output mv_dir, output mv_valid, input mv_ready);
  modport slave  (input mv_dir, input mv_valid, output mv_ready);
endinterface

// File: rtl/move_cmd_scheduler_fifo.sv
// Small direction FIFO with flush; a push while full without a pop is dropped and flagged.
module move_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [1:0]               wdata,
  output logic [1:0]               rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][1:0] mem;
  logic [AW-1:0]         wptr, rptr;
  logic                  full, do_push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A pop on a full FIFO frees the slot the concurrent push lands in.
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/move_cmd_scheduler.sv
// Turns decoder key presses (plus auto-repeat while held) into paced moves for the game core.
module move_cmd_scheduler
  import move_cmd_scheduler_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int GAP_CYCLES    = 5_000_000,
  parameter int REPEAT_CYCLES = 25_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [1:0]             key_data,
  input  logic                   key_signal,
  move_cmd_scheduler_if.master   mv,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);
  localparam int GAP_W = cnt_w(GAP_CYCLES);

  logic             sig_q, press, rpt_hit, push, pop;
  logic             fifo_empty, fifo_drop;
  logic [1:0]       head, mv_dir_nxt;
  logic             mv_valid_nxt;
  logic [GAP_W-1:0] gap_cnt;
  issue_st_e        state, state_nxt;

  assign press = key_signal & ~sig_q & enable;
  assign push  = (press | rpt_hit) & (key_data != DIR_NONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sig_q <= 1'b0;
    else      sig_q <= key_signal;
  end

  generate
    if (REPEAT_CYCLES > 0) begin : g_rpt
      localparam int RPT_W = cnt_w(REPEAT_CYCLES);
      logic [RPT_W-1:0] rpt_cnt;

      // A press restarts the hold timer, so press and repeat never coincide.
      assign rpt_hit = enable & key_signal & ~press &
                       (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               rpt_cnt <= '0;
        else if (!enable || press || !key_signal) rpt_cnt <= '0;
        else if (rpt_hit)                       rpt_cnt <= '0;
        else                                    rpt_cnt <= rpt_cnt + 1'b1;
      end
    end else begin : g_no_rpt
      assign rpt_hit = 1'b0;
    end
  endgenerate

  move_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (~enable),
    .push  (push),
    .pop   (pop),
    .wdata (key_data),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    mv_valid_nxt = mv.mv_valid;
    mv_dir_nxt   = mv.mv_dir;
    if (!enable) begin
      state_nxt    = ST_IDLE;
      mv_valid_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (!fifo_empty) begin
          pop          = 1'b1;
          mv_dir_nxt   = head;
          mv_valid_nxt = 1'b1;
          state_nxt    = ST_ISSUE;
        end
        ST_ISSUE: if (mv.mv_ready) begin
          mv_valid_nxt = 1'b0;
          state_nxt    = ST_GAP;
        end
        ST_GAP: if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      mv.mv_valid <= 1'b0;
      mv.mv_dir   <= DIR_NONE;
    end else begin
      state       <= state_nxt;
      mv.mv_valid <= mv_valid_nxt;
      mv.mv_dir   <= mv_dir_nxt;
    end
  end

  // Held at zero outside GAP so the gap always starts from a clean count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            gap_cnt <= '0;
    else if (!enable || state != ST_GAP) gap_cnt <= '0;
    else                                 gap_cnt <= gap_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           overflow <= 1'b0;
    else if (!enable)   overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_move_cmd_scheduler.sv
// Directed scenarios plus random traffic, checked every cycle against a queue/timestamp model.
module tb_move_cmd_scheduler;
  localparam int DEPTH = 4;
  localparam int GAP   = 3;
  localparam int RPT   = 8;

  logic       clk = 1'b0, rst = 1'b0, enable = 1'b0, key_signal = 1'b0;
  logic [1:0] key_data = 2'd0;
  logic [2:0] fifo_count;
  logic       overflow;
  int unsigned n_vec = 0, n_err = 0;

  move_cmd_scheduler_if mv_if();

  move_cmd_scheduler #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .REPEAT_CYCLES(RPT)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .key_data   (key_data),
    .key_signal (key_signal),
    .mv         (mv_if),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: pending moves as a queue, the gap as an earliest-issue cycle number.
  int unsigned cyc = 0, ready_at = 0, age = 0;
  logic [1:0]  q[$];
  bit          busy = 0, m_ovf = 0, key_prev = 0;
  logic [1:0]  m_dir = 2'd0;

  always @(posedge clk or negedge rst) begin : model
    bit pr, rp;
    if (!rst) begin
      q.delete(); busy = 0; m_dir = 2'd0; m_ovf = 0; ready_at = 0; age = 0; key_prev = 0;
    end else begin
      cyc++;
      if (!enable) begin
        q.delete(); busy = 0; m_ovf = 0; age = 0; ready_at = 0;
      end else begin
        pr = key_signal && !key_prev;
        rp = 0;
        if (!key_signal || pr) age = 0;
        else begin
          age++;
          rp = (age % RPT) == 0;
        end
        if (busy) begin
          if (mv_if.mv_ready) begin
            busy = 0;
            ready_at = cyc + GAP + 1;
          end
        end else if (q.size() > 0 && cyc >= ready_at) begin
          m_dir = q.pop_front();
          busy = 1;
        end
        if ((pr || rp) && key_data != 2'd0) begin
          if (q.size() < DEPTH) q.push_back(key_data);
          else m_ovf = 1;
        end
      end
      key_prev = key_signal;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("mv_valid", 32'(mv_if.mv_valid), 32'(busy));
      chk("mv_dir", 32'(mv_if.mv_dir), 32'(m_dir));
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int rises[$];
    logic [1:0] rdirs[$];
    bit prev;
    int nvalid;

    mv_if.mv_ready = 1'b1;
    step(3);
    chk("rst_mv_valid", 32'(mv_if.mv_valid), 0);
    chk("rst_mv_dir", 32'(mv_if.mv_dir), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst = 1'b1;
    enable = 1'b1;
    step(2);

    // Single press: queued next edge, valid one edge later, one cycle wide.
    key_data = 2'd2; key_signal = 1'b1;
    step();
    chk("t1_count", 32'(fifo_count), 1);
    chk("t1_valid_early", 32'(mv_if.mv_valid), 0);
    key_signal = 1'b0;
    step();
    chk("t1_valid", 32'(mv_if.mv_valid), 1);
    chk("t1_dir", 32'(mv_if.mv_dir), 2);
    step();
    chk("t1_valid_drop", 32'(mv_if.mv_valid), 0);
    step(8);

    // Stall: move held while the core is not ready.
    mv_if.mv_ready = 1'b0;
    key_data = 2'd3; key_signal = 1'b1;
    step();
    key_signal = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t2_hold_valid", 32'(mv_if.mv_valid), 1);
      chk("t2_hold_dir", 32'(mv_if.mv_dir), 3);
    end
    mv_if.mv_ready = 1'b1;
    step();
    chk("t2_release", 32'(mv_if.mv_valid), 0);
    step(8);

    // Overflow: one issued and held, four queued, one dropped; disable flushes.
    mv_if.mv_ready = 1'b0;
    key_data = 2'd1;
    for (int i = 0; i < 6; i++) begin
      key_signal = 1'b1; step();
      key_signal = 1'b0; step();
    end
    chk("t3_count", 32'(fifo_count), 4);
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_valid", 32'(mv_if.mv_valid), 1);
    enable = 1'b0;
    step();
    chk("t3_flush_count", 32'(fifo_count), 0);
    chk("t3_flush_ovf", 32'(overflow), 0);
    chk("t3_flush_valid", 32'(mv_if.mv_valid), 0);
    enable = 1'b1; mv_if.mv_ready = 1'b1;
    step(8);

    // Auto-repeat: 30 clocks held yields four moves.
    key_data = 2'd1; key_signal = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (mv_if.mv_valid) nvalid++;
    end
    key_signal = 1'b0;
    chk("t4_repeat_moves", 32'(nvalid), 4);
    step(12);

    // Gap: three quick presses issue in order, GAP+1 clocks from accept to next valid.
    prev = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 6) begin
        key_signal = (i % 2 == 0);
        if (i % 2 == 0) key_data = 2'(i / 2 + 1);
      end
      step();
      if (mv_if.mv_valid && !prev) begin
        rises.push_back(i);
        rdirs.push_back(mv_if.mv_dir);
      end
      prev = mv_if.mv_valid;
    end
    chk("t5_rises", 32'(rises.size()), 3);
    if (rises.size() == 3) begin
      chk("t5_dir0", 32'(rdirs[0]), 1);
      chk("t5_dir1", 32'(rdirs[1]), 2);
      chk("t5_dir2", 32'(rdirs[2]), 3);
      chk("t5_gap01", 32'(rises[1] - rises[0] - 1), GAP + 1);
      chk("t5_gap12", 32'(rises[2] - rises[1] - 1), GAP + 1);
    end
    key_data = 2'd0; key_signal = 1'b1;
    step();
    chk("t5_none_count", 32'(fifo_count), 0);
    key_signal = 1'b0;
    step(3);
    chk("t5_none_valid", 32'(mv_if.mv_valid), 0);
    step(4);

    // Reset mid-operation clears everything at once; nothing stale issues afterwards.
    mv_if.mv_ready = 1'b0;
    key_data = 2'd2;
    for (int i = 0; i < 3; i++) begin
      key_signal = 1'b1; step();
      key_signal = 1'b0; step();
    end
    chk("t6_pre_valid", 32'(mv_if.mv_valid), 1);
    chk("t6_pre_count", 32'(fifo_count), 2);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(mv_if.mv_valid), 0);
    chk("t6_rst_dir", 32'(mv_if.mv_dir), 0);
    chk("t6_rst_count", 32'(fifo_count), 0);
    step();
    rst = 1'b1; mv_if.mv_ready = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (mv_if.mv_valid) nvalid++;
    end
    chk("t6_no_stale", 32'(nvalid), 0);

    // Random traffic, model-checked every cycle.
    for (int i = 0; i < 1200; i++) begin
      mv_if.mv_ready = ($urandom_range(0, 99) < 60);
      enable = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, (i < 600) ? 3 : 15) == 0) key_signal = ~key_signal;
      if ($urandom_range(0, 5) == 0) key_data = 2'($urandom_range(0, 3));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
